// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store sequencer between the register file's memory ports and an
// external handshaked memory bus. A request in IDLE captures the address,
// store data, destination and access type. One bus transaction then runs with
// wait-state support and an optional timeout. Load data returns to the
// register file with a one-hot, active-low, single-cycle write strobe.
//
// Optional feature macro: MEM_ACCESS_BYTE_EN
//   defined   : BYTEb=0 selects a byte access (BITS must be 16). Byte lanes are
//               chosen by addr[0], store data is replicated on both lanes, and
//               the loaded lane is zero-extended.
//   undefined : BYTEb is ignored and every access is a full word.
//
// Ports
//   CLK        in   clock, rising edge
//   RSTb       in   asynchronous active-low reset
//   LD_STARTb  in   active-low load request (sampled in IDLE)
//   ST_STARTb  in   active-low store request (sampled in IDLE)
//   BYTEb      in   active-low byte access select
//   DEST_SEL   in   load destination register index
//   addr_in    in   access address
//   data_in    in   store data
//   inM        out  load data to the register file
//   LD_reg_Mb  out  active-low one-hot load strobe
//   BUSYb      out  low while a transaction is in flight
//   ERRb       out  one-cycle active-low error pulse
//   BUS_ADDR   out  memory address
//   BUS_WDATA  out  memory write data
//   BUS_RDATA  in   memory read data
//   BUS_RDb    out  active-low read strobe
//   BUS_WRb    out  active-low write strobe
//   BUS_BEb    out  active-low byte-lane enables (bit 0 = low byte)
//   BUS_ACKb   in   active-low transfer acknowledge
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int BITS       = 16,
   parameter int REG_BITS   = 3,
   parameter int WAIT_LIMIT = 15
) (
   input  logic                   CLK,
   input  logic                   RSTb,
   input  logic                   LD_STARTb,
   input  logic                   ST_STARTb,
   input  logic                   BYTEb,
   input  logic [REG_BITS-1:0]    DEST_SEL,
   input  logic [BITS-1:0]        addr_in,
   input  logic [BITS-1:0]        data_in,
   output logic [BITS-1:0]        inM,
   output logic [2**REG_BITS-1:0] LD_reg_Mb,
   output logic                   BUSYb,
   output logic                   ERRb,
   output logic [BITS-1:0]        BUS_ADDR,
   output logic [BITS-1:0]        BUS_WDATA,
   input  logic [BITS-1:0]        BUS_RDATA,
   output logic                   BUS_RDb,
   output logic                   BUS_WRb,
   output logic [1:0]             BUS_BEb,
   input  logic                   BUS_ACKb
);

   localparam int         NREG     = 2**REG_BITS;
   localparam int         HALF     = BITS / 2;
   localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WB     = 2'd2
   } state_t;

   state_t                state_q,     state_d;
   logic                  op_ld_q,     op_ld_d;
   logic [REG_BITS-1:0]   dest_q,      dest_d;
   logic [7:0]            wait_cnt_q,  wait_cnt_d;
   logic [BITS-1:0]       in_m_q,      in_m_d;
   logic [NREG-1:0]       ld_reg_q,    ld_reg_d;
   logic                  busy_q,      busy_d;
   logic                  err_q,       err_d;
   logic [BITS-1:0]       bus_addr_q,  bus_addr_d;
   logic [BITS-1:0]       bus_wdata_q, bus_wdata_d;
   logic                  bus_rd_q,    bus_rd_d;
   logic                  bus_wr_q,    bus_wr_d;
   logic [1:0]            bus_be_q,    bus_be_d;

`ifdef MEM_ACCESS_BYTE_EN
   logic                  byte_q,      byte_d;
   logic [HALF-1:0]       rd_lane;
`else
   // BYTEb has no function in the word-only build.
   logic                  unused_byteb;
   assign unused_byteb = BYTEb;
`endif

   logic [BITS-1:0]       load_data;

`ifdef MEM_ACCESS_BYTE_EN
   // addr[0]=1 selects the high lane, addr[0]=0 the low lane.
   assign rd_lane   = bus_addr_q[0] ? BUS_RDATA[BITS-1:HALF] : BUS_RDATA[HALF-1:0];
   assign load_data = byte_q ? {{(BITS-HALF){1'b0}}, rd_lane} : BUS_RDATA;
`else
   assign load_data = BUS_RDATA;
`endif

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q     <= IDLE;
         op_ld_q     <= 1'b0;
         dest_q      <= '0;
         wait_cnt_q  <= '0;
         in_m_q      <= '0;
         ld_reg_q    <= '1;
         busy_q      <= 1'b1;
         err_q       <= 1'b1;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_rd_q    <= 1'b1;
         bus_wr_q    <= 1'b1;
         bus_be_q    <= 2'b11;
`ifdef MEM_ACCESS_BYTE_EN
         byte_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_ld_q     <= op_ld_d;
         dest_q      <= dest_d;
         wait_cnt_q  <= wait_cnt_d;
         in_m_q      <= in_m_d;
         ld_reg_q    <= ld_reg_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_rd_q    <= bus_rd_d;
         bus_wr_q    <= bus_wr_d;
         bus_be_q    <= bus_be_d;
`ifdef MEM_ACCESS_BYTE_EN
         byte_q      <= byte_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      op_ld_d     = op_ld_q;
      dest_d      = dest_q;
      wait_cnt_d  = wait_cnt_q;
      in_m_d      = in_m_q;
      ld_reg_d    = '1;         // the load strobe and error flag are pulses
      busy_d      = busy_q;
      err_d       = 1'b1;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_rd_d    = bus_rd_q;
      bus_wr_d    = bus_wr_q;
      bus_be_d    = bus_be_q;
`ifdef MEM_ACCESS_BYTE_EN
      byte_d      = byte_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (!LD_STARTb && !ST_STARTb) begin
               // Conflicting requests: reject both and flag it.
               err_d = 1'b0;
            end else if (!LD_STARTb || !ST_STARTb) begin
               state_d    = ACCESS;
               op_ld_d    = !LD_STARTb;
               dest_d     = DEST_SEL;
               wait_cnt_d = '0;
               busy_d     = 1'b0;
               bus_addr_d = addr_in;
               // Strobes are registered here so they are low for the whole
               // first ACCESS cycle.
               bus_rd_d   = LD_STARTb;
               bus_wr_d   = !LD_STARTb;
`ifdef MEM_ACCESS_BYTE_EN
               byte_d = !BYTEb;
               if (!BYTEb) begin
                  bus_be_d    = addr_in[0] ? 2'b01 : 2'b10;
                  bus_wdata_d = {data_in[HALF-1:0], data_in[HALF-1:0]};
               end else begin
                  bus_be_d    = 2'b00;
                  bus_wdata_d = data_in;
               end
`else
               bus_be_d    = 2'b00;
               bus_wdata_d = data_in;
`endif
            end
         end

         ACCESS: begin
            // Ack is checked first so an ack on the limit cycle wins.
            if (!BUS_ACKb) begin
               bus_rd_d = 1'b1;
               bus_wr_d = 1'b1;
               bus_be_d = 2'b11;
               if (op_ld_q) begin
                  state_d = WB;
                  in_m_d  = load_data;
                  for (int i = 0; i < NREG; i++) begin
                     ld_reg_d[i] = (dest_q != REG_BITS'(i));
                  end
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b1;
               end
            end else if ((WAIT_LIM != 8'd0) && ((wait_cnt_q + 8'd1) == WAIT_LIM)) begin
               state_d    = IDLE;
               wait_cnt_d = wait_cnt_q + 8'd1;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               bus_rd_d   = 1'b1;
               bus_wr_d   = 1'b1;
               bus_be_d   = 2'b11;
            end else begin
               // Saturate so an unlimited wait cannot wrap the counter.
               wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            end
         end

         WB: begin
            state_d = IDLE;
            busy_d  = 1'b1;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b1;
         end
      endcase
   end

   assign inM       = in_m_q;
   assign LD_reg_Mb = ld_reg_q;
   assign BUSYb     = busy_q;
   assign ERRb      = err_q;
   assign BUS_ADDR  = bus_addr_q;
   assign BUS_WDATA = bus_wdata_q;
   assign BUS_RDb   = bus_rd_q;
   assign BUS_WRb   = bus_wr_q;
   assign BUS_BEb   = bus_be_q;

endmodule
